// File: rtl/imm_decoder.sv
// Immediate decoder: LEB128 (u32/s32/s64) or raw LE f32/f64 bytes into a 64-bit operand.
// done/trap arrive the cycle after the final byte; in_ready is held high throughout FETCH and in_valid gaps simply stall.
module imm_decoder #(
  parameter logic [2:0] TRAP_MALFORMED = 3'd4,
  parameter logic [2:0] TRAP_BADKIND   = 3'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  kind,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] value,
  output logic        done,
  output logic        busy,
  output logic [2:0]  trap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [2:0] K_U32 = 3'd0;
  localparam logic [2:0] K_S32 = 3'd1;
  localparam logic [2:0] K_S64 = 3'd2;
  localparam logic [2:0] K_F32 = 3'd3;
  localparam logic [2:0] K_F64 = 3'd4;

  logic [1:0]  state;
  logic [2:0]  kind_q;
  logic [3:0]  count;
  logic [5:0]  shift;
  logic [63:0] acc;

  logic        is_leb, is_signed, narrow, last_slot, byte_final, range_bad, bad_tail;
  logic [5:0]  shift_step;
  logic [63:0] contrib, acc_next, ext_mask, result;

  assign in_ready = (state == S_FETCH);
  assign busy     = (state == S_FETCH);

  always_comb begin
    is_leb     = (kind_q == K_U32) || (kind_q == K_S32) || (kind_q == K_S64);
    is_signed  = (kind_q == K_S32) || (kind_q == K_S64);
    narrow     = (kind_q == K_U32) || (kind_q == K_S32) || (kind_q == K_F32);
    shift_step = is_leb ? 6'd7 : 6'd8;

    if (is_leb)
      last_slot = (count == ((kind_q == K_S64) ? 4'd9 : 4'd4));
    else
      last_slot = (count == ((kind_q == K_F64) ? 4'd7 : 4'd3));

    // Raw kinds have no continuation bit: only the byte count ends them.
    byte_final = is_leb ? (!in_data[7] || last_slot) : last_slot;

    range_bad = 1'b0;
    case (kind_q)
      K_U32:   range_bad = (in_data[6:4] != 3'b000);
      K_S32:   range_bad = (in_data[6:4] != {3{in_data[3]}});
      K_S64:   range_bad = (in_data[6:1] != {6{in_data[0]}});
      default: range_bad = 1'b0;
    endcase
    bad_tail = is_leb && last_slot && (in_data[7] || range_bad);

    contrib  = is_leb ? ({57'd0, in_data[6:0]} << shift) : ({56'd0, in_data} << shift);
    acc_next = acc | contrib;

    // A shift of 64 or more (full-length s64) yields an empty mask.
    ext_mask = 64'd0;
    if (is_signed && in_data[6])
      ext_mask = ~64'd0 << ({1'b0, shift} + 7'd7);

    result = acc_next | ext_mask;
    if (narrow)
      result[63:32] = 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      kind_q <= K_U32;
      count  <= 4'd0;
      shift  <= 6'd0;
      acc    <= 64'd0;
      value  <= 64'd0;
      done   <= 1'b0;
      trap   <= 3'd0;
    end else begin
      done <= 1'b0;
      if (state == S_FETCH) begin
        if (in_valid) begin
          if (bad_tail) begin
            state <= S_ERROR;
            trap  <= TRAP_MALFORMED;
          end else if (byte_final) begin
            value <= result;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            acc   <= acc_next;
            count <= count + 4'd1;
            shift <= shift + shift_step;
          end
        end
      end else if (start) begin
        if (kind <= K_F64) begin
          state  <= S_FETCH;
          kind_q <= kind;
          count  <= 4'd0;
          shift  <= 6'd0;
          acc    <= 64'd0;
          value  <= 64'd0;
          trap   <= 3'd0;
        end else begin
          state <= S_ERROR;
          trap  <= TRAP_BADKIND;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_decoder.sv
// Bench for imm_decoder: directed vectors plus randomized decodes against an arithmetic reference model.
module tb_imm_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  kind;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] value;
  logic        done;
  logic        busy;
  logic [2:0]  trap;

  int n_tests = 0;
  int n_fail  = 0;

  typedef logic [7:0] bq_t[$];

  imm_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .kind     (kind),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .done     (done),
    .busy     (busy),
    .trap     (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode as a mathematical integer, then range-check it against the target type.
  function automatic void ref_model(input logic [2:0] k, input bq_t b, output bit ok, output logic [63:0] val);
    logic [127:0]        acc;
    logic signed [127:0] s;
    logic signed [127:0] lim;
    int                  n;
    n   = b.size();
    acc = '0;
    ok  = 1'b1;
    if (k == 3'd3 || k == 3'd4) begin
      foreach (b[i]) acc = acc + (128'(b[i]) << (8 * i));
      val = acc[63:0];
      return;
    end
    foreach (b[i]) acc = acc + (128'(b[i][6:0]) << (7 * i));
    if (k != 3'd0 && b[n-1][6])
      acc = acc - (128'd1 << (7 * n));
    s = $signed(acc);
    if (b[n-1][7]) ok = 1'b0;
    case (k)
      3'd0: if (acc >= (128'd1 << 32)) ok = 1'b0;
      3'd1: begin
        lim = 128'sd1 <<< 31;
        if (s >= lim || s < -lim) ok = 1'b0;
      end
      default: begin
        lim = 128'sd1 <<< 63;
        if (s >= lim || s < -lim) ok = 1'b0;
      end
    endcase
    val = (k == 3'd2) ? acc[63:0] : {32'd0, acc[31:0]};
  endfunction

  task automatic gen(input logic [2:0] k, output bq_t b);
    int         n;
    int         mx;
    logic [7:0] x;
    b = {};
    if (k == 3'd3 || k == 3'd4) begin
      n = (k == 3'd4) ? 8 : 4;
      repeat (n) b.push_back(8'($urandom));
      return;
    end
    mx = (k == 3'd2) ? 10 : 5;
    n  = $urandom_range(1, mx);
    for (int i = 0; i < n - 1; i++) b.push_back(8'($urandom) | 8'h80);
    x = 8'($urandom);
    if (n < mx) x[7] = 1'b0;
    else if ($urandom_range(0, 1) == 1) begin
      case (k)
        3'd0:    x = x & 8'h0F;
        3'd1:    x = x[3] ? (8'h78 | (x & 8'h07)) : (x & 8'h07);
        default: x = x[0] ? 8'h7F : 8'h00;
      endcase
    end
    b.push_back(x);
  endtask

  // Called just after a rising edge; leaves the bench just after the edge where done/trap appear.
  task automatic run_decode(input logic [2:0] k, input bq_t b, input int stall_n, output bit ok, output logic [63:0] got);
    logic [63:0] exp;
    int          ns;
    ref_model(k, b, ok, exp);
    start = 1'b1; kind = k; in_valid = 1'b0;
    tick();
    start = 1'b0;
    check_eq("fetch_ready", 64'(in_ready), 64'd1);
    check_eq("fetch_busy",  64'(busy),     64'd1);
    check_eq("fetch_nodone", 64'(done),    64'd0);
    check_eq("start_trap_clr", 64'(trap),  64'd0);
    check_eq("start_val_clr", value,       64'd0);
    foreach (b[i]) begin
      ns = (stall_n < 0) ? $urandom_range(0, 2) : stall_n;
      repeat (ns) begin
        start    = 1'($urandom_range(0, 1));
        kind     = 3'($urandom_range(0, 7));
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
        check_eq("stall_ready",  64'(in_ready), 64'd1);
        check_eq("stall_nodone", 64'(done),     64'd0);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = b[i];
      tick();
      in_valid = 1'b0;
      if (i < b.size() - 1)
        check_eq("mid_done_ready", 64'({done, in_ready}), 64'b01);
    end
    if (ok) begin
      check_eq("done",     64'(done),     64'd1);
      check_eq("trap0",    64'(trap),     64'd0);
      check_eq("value",    value,         exp);
      check_eq("not_busy", 64'(busy),     64'd0);
    end else begin
      check_eq("err_nodone",     64'(done),     64'd0);
      check_eq("trap_malformed", 64'(trap),     64'd4);
      check_eq("err_ready",      64'(in_ready), 64'd0);
    end
    got = value;
  endtask

  task automatic bad_kind(input logic [2:0] k);
    start = 1'b1; kind = k; in_valid = 1'b0;
    tick();
    start = 1'b0;
    check_eq("badkind_trap",   64'(trap),     64'd5);
    check_eq("badkind_ready",  64'(in_ready), 64'd0);
    check_eq("badkind_nodone", 64'(done),     64'd0);
    in_valid = 1'b1; in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    check_eq("badkind_hold",   64'(trap),     64'd5);
    check_eq("badkind_ready2", 64'(in_ready), 64'd0);
  endtask

  initial begin
    bq_t         b;
    bit          ok;
    bit          last_ok;
    logic [63:0] got;
    logic [2:0]  k;

    reset = 1'b1; start = 1'b0; kind = 3'd0; in_data = 8'd0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_value", value,          64'd0);
    check_eq("rst_done",  64'(done),      64'd0);
    check_eq("rst_busy",  64'(busy),      64'd0);
    check_eq("rst_ready", 64'(in_ready),  64'd0);
    check_eq("rst_trap",  64'(trap),      64'd0);
    reset = 1'b0;
    tick();

    b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0};
    run_decode(3'd4, b, 0, ok, got);
    check_eq("f64_lit", got, 64'hC000000000000000);

    b = '{8'h7F};
    run_decode(3'd1, b, 0, ok, got);
    check_eq("s32_lit", got, 64'h00000000FFFFFFFF);

    b = '{8'hE5, 8'h8E, 8'h26};
    run_decode(3'd0, b, 0, ok, got);
    check_eq("u32_lit", got, 64'h0000000000098765);

    b = '{8'hC0, 8'hBB, 8'h78};
    run_decode(3'd2, b, 2, ok, got);
    check_eq("s64_lit", got, 64'hFFFFFFFFFFFE1DC0);

    b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_decode(3'd0, b, 0, ok, got);
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
    run_decode(3'd0, b, 0, ok, got);
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run_decode(3'd0, b, 0, ok, got);
    check_eq("u32_max_lit", got, 64'h00000000FFFFFFFF);

    bad_kind(3'd7);
    b = '{8'h05};
    run_decode(3'd0, b, 0, ok, got);
    check_eq("after_bad_lit", got, 64'd5);

    // Abort an f64 decode with an asynchronous reset between clock edges.
    start = 1'b1; kind = 3'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1));
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy",  64'(busy),     64'd0);
    check_eq("arst_ready", 64'(in_ready), 64'd0);
    check_eq("arst_value", value,         64'd0);
    check_eq("arst_done",  64'(done),     64'd0);
    check_eq("arst_trap",  64'(trap),     64'd0);
    tick();
    reset = 1'b0;
    tick();

    b = '{8'h00, 8'h00, 8'h80, 8'h3F};
    run_decode(3'd3, b, 0, ok, got);
    check_eq("f32_lit", got, 64'h000000003F800000);
    last_ok = ok;

    for (int it = 0; it < 250; it++) begin
      if (last_ok && $urandom_range(0, 2) == 0) begin
        tick();
        check_eq("idle_nodone",  64'(done), 64'd0);
        check_eq("idle_hold",    value,     got);
      end
      k = 3'($urandom_range(0, 7));
      if (k > 3'd4) begin
        bad_kind(k);
        last_ok = 1'b0;
      end else begin
        gen(k, b);
        run_decode(k, b, -1, ok, got);
        last_ok = ok;
      end
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
